stage_to_stream: RTL

- Drains a completed FFT stage memory into a serial sample stream. Sits directly downstream of the final stage.
- Issues N read addresses, optionally in bit-reversed order so the output is in natural frequency order.
- Pairs each sample with its metadata word, popped from the upstream mstore FIFO.
- Emits one sample per cycle with out_nd strobes. A pulsed finished hands control back to the FFT controller FSM.

---
 rtl/stage_to_stream_pkg.sv | 42 ++++
 rtl/stage_to_stream.sv | 103 ++++++++++
 2 files changed

// File: rtl/stage_to_stream_pkg.sv
// Shared types and helpers for the stage drain logic.
// Holds FSM encoding, pipeline bundle and address helpers.
package stage_to_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  typedef struct packed {
    logic v;
    logic last;
  } pipe_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Reverses the low w bits of v; bits above w come back zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r = {r[30:0], s[0]};
        s = {1'b0, s[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stage_to_stream.sv
// Drains a finished FFT stage memory into a sample stream.
// Reads N words (optionally bit-reversed) and pairs them with metadata.
module stage_to_stream
  import stage_to_stream_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = clog2(N),
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [LOG_N-1:0]  addr,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_mread,
  input  logic [MWIDTH-1:0] in_m,
  output logic              out_nd,
  output logic [WIDTH-1:0]  out_data,
  output logic [MWIDTH-1:0] out_m,
  output logic              finished,
  output logic              error
);

  state_t           state;
  state_t           state_n;
  logic [LOG_N-1:0] cnt;
  logic [LOG_N-1:0] cnt_n;
  logic             err_n;
  logic             last_rd;
  pipe_t            p1;

  assign last_rd = (cnt == LOG_N'(N - 1));

  // Next state, read address and mstore pop.
  // A start seen on the final read restarts the
  // frame directly so consecutive frames abut.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = error;
    addr      = '0;
    out_mread = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          cnt_n   = '0;
        end
      end
      READ: begin
        out_mread = 1'b1;
        if (BITREV != 0)
          addr = LOG_N'(bitrev(32'(cnt), LOG_N));
        else
          addr = cnt;
        if (last_rd) begin
          if (start) cnt_n = '0;
          else state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
          if (start) err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, read counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      error <= err_n;
    end
  end

  // Two-stage valid pipeline matching read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1       <= '0;
      out_nd   <= 1'b0;
      finished <= 1'b0;
      out_data <= '0;
      out_m    <= '0;
    end else begin
      p1.v     <= (state == READ);
      p1.last  <= (state == READ) && last_rd;
      out_nd   <= p1.v;
      finished <= p1.last;
      if (p1.v) begin
        out_data <= in_data;
        out_m    <= in_m;
      end
    end
  end

endmodule
